// File: rtl/miner_pkg.sv
// Shared types and default sizing for the nonce scheduler and its arbiter.
package miner_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sched_state_t;

    localparam int DEF_NUM_CORES  = 4;
    localparam int DEF_NONCE_W    = 32;
    localparam int DEF_CHUNK_LOG2 = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first requester at or after i_ptr (wrapping) gets a one-hot grant.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_idx,
    output logic          o_valid
);

    logic [IW-1:0] w_pos;
    logic          w_hit;

    // Scan N positions starting at the pointer; the first request found wins.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_pos   = '0;
        w_hit   = 1'b0;
        for (int k = 0; k < N; k++) begin
            w_pos          = IW'((int'(i_ptr) + k) % N);
            w_hit          = !o_valid && i_req[w_pos];
            o_grant[w_pos] = o_grant[w_pos] | w_hit;
            o_idx          = w_hit ? w_pos : o_idx;
            o_valid        = o_valid | w_hit;
        end
    end

endmodule

// File: rtl/miner_nonce_scheduler.sv
// Splits a nonce range into chunks, dispatches them round-robin to idle hash cores,
// and collects found/complete status for the CSR block.
module miner_nonce_scheduler
    import miner_pkg::*;
#(
    parameter int NUM_CORES  = DEF_NUM_CORES,
    parameter int NONCE_W    = DEF_NONCE_W,
    parameter int CHUNK_LOG2 = DEF_CHUNK_LOG2
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                i_cfg_start,
    input  logic                                i_cfg_abort,
    input  logic [NONCE_W-1:0]                  i_cfg_nonce_first,
    input  logic [NONCE_W-1:0]                  i_cfg_nonce_last,
    output logic [NUM_CORES-1:0]                o_core_start,
    output logic [NUM_CORES*NONCE_W-1:0]        o_core_base,
    output logic [NUM_CORES*(CHUNK_LOG2+1)-1:0] o_core_count,
    output logic [NUM_CORES-1:0]                o_core_abort,
    input  logic [NUM_CORES-1:0]                i_core_busy,
    input  logic [NUM_CORES-1:0]                i_core_found,
    input  logic [NUM_CORES*NONCE_W-1:0]        i_core_found_nonce,
    output logic                                o_busy,
    output logic                                o_complete,
    output logic                                o_found,
    output logic [NONCE_W-1:0]                  o_found_nonce
);

    localparam int CW  = CHUNK_LOG2 + 1;
    localparam int NW1 = NONCE_W + 1;
    localparam int IW  = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam logic [NW1-1:0] CHUNK_SZ = NW1'(1'b1) << CHUNK_LOG2;

    sched_state_t   r_state;
    logic [NW1-1:0] r_next;
    logic [NW1-1:0] r_last;
    logic [IW-1:0]  r_rr;
    logic           r_ignore_found;

    logic                 w_accept;
    logic                 w_abort;
    logic                 w_exhaust;
    logic                 w_found_ok;
    logic                 w_found_hit;
    logic                 w_dispatch_en;
    logic                 w_dispatch;
    logic                 w_arb_valid;
    logic                 w_drain_done;
    logic [NW1-1:0]       w_first;
    logic [NW1-1:0]       w_cur;
    logic [NW1-1:0]       w_last;
    logic [NW1-1:0]       w_rem;
    logic [NW1-1:0]       w_next;
    logic [CW-1:0]        w_count;
    logic [NUM_CORES-1:0] w_req;
    logic [NUM_CORES-1:0] w_grant;
    logic [IW-1:0]        w_idx;
    logic [NONCE_W-1:0]   w_found_val;

    // The accepting cycle dispatches straight from the cfg values so the first chunk leaves one cycle after start.
    assign w_first       = {1'b0, i_cfg_nonce_first};
    assign w_accept      = i_cfg_start && ((r_state == IDLE) || (r_state == DONE));
    assign w_cur         = w_accept ? w_first : r_next;
    assign w_last        = w_accept ? {1'b0, i_cfg_nonce_last} : r_last;
    assign w_exhaust     = w_cur > w_last;
    assign w_abort       = i_cfg_abort && (r_state == RUN);
    assign w_found_ok    = !o_found && ((r_state == RUN) || ((r_state == DRAIN) && !r_ignore_found));
    assign w_found_hit   = w_found_ok && (|i_core_found);
    assign w_dispatch_en = !w_exhaust && (w_accept || ((r_state == RUN) && !w_found_hit && !w_abort));
    assign w_req         = ~i_core_busy & ~o_core_start;
    assign w_dispatch    = w_dispatch_en && w_arb_valid;
    assign w_rem         = w_last - w_cur + NW1'(1'b1);
    assign w_count       = (w_rem > CHUNK_SZ) ? CHUNK_SZ[CW-1:0] : w_rem[CW-1:0];
    assign w_next        = w_cur + {{(NW1-CW){1'b0}}, w_count};
    assign w_drain_done  = (r_state == DRAIN) && !(|i_core_busy) && !(|o_core_start);

    rr_arbiter #(
        .N  (NUM_CORES),
        .IW (IW)
    ) u_arb (
        .i_req   (w_req),
        .i_ptr   (r_rr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_valid (w_arb_valid)
    );

    // Lowest-index core wins when several report a golden nonce in the same cycle.
    always_comb begin
        w_found_val = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            w_found_val = i_core_found[i] ? i_core_found_nonce[i*NONCE_W +: NONCE_W] : w_found_val;
        end
    end

    // Scheduler state machine, dispatch datapath and all registered outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state        <= IDLE;
            r_next         <= '0;
            r_last         <= '0;
            r_rr           <= '0;
            r_ignore_found <= 1'b0;
            o_core_start   <= '0;
            o_core_base    <= '0;
            o_core_count   <= '0;
            o_core_abort   <= '0;
            o_busy         <= 1'b0;
            o_complete     <= 1'b0;
            o_found        <= 1'b0;
            o_found_nonce  <= '0;
        end else begin
            o_core_start <= w_dispatch ? w_grant : '0;
            for (int i = 0; i < NUM_CORES; i++) begin
                if (w_dispatch && w_grant[i]) begin
                    o_core_base[i*NONCE_W +: NONCE_W] <= w_cur[NONCE_W-1:0];
                    o_core_count[i*CW +: CW]          <= w_count;
                end
            end
            // The extra counter bit makes a range ending at all-ones exhaust instead of wrapping to 0.
            if (w_dispatch) begin
                r_next <= w_next;
                r_rr   <= (w_idx == IW'(NUM_CORES - 1)) ? '0 : w_idx + IW'(1);
            end else if (w_accept) begin
                r_next <= w_first;
            end
            if (w_found_hit) begin
                o_found       <= 1'b1;
                o_found_nonce <= w_found_val;
            end
            case (r_state)
                IDLE, DONE: begin
                    if (w_accept) begin
                        r_state        <= w_exhaust ? DRAIN : RUN;
                        r_last         <= w_last;
                        r_ignore_found <= 1'b0;
                        o_busy         <= 1'b1;
                        o_complete     <= 1'b0;
                        o_found        <= 1'b0;
                        o_found_nonce  <= '0;
                    end
                end
                RUN: begin
                    if (w_found_hit || w_abort) begin
                        r_state        <= DRAIN;
                        r_ignore_found <= !w_found_hit;
                        o_core_abort   <= '1;
                    end else if (w_exhaust) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_drain_done) begin
                        r_state      <= DONE;
                        o_busy       <= 1'b0;
                        o_complete   <= 1'b1;
                        o_core_abort <= '0;
                    end else if (w_found_hit) begin
                        o_core_abort <= '1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_miner_nonce_scheduler.sv
// Self-checking bench: behavioural hash-core model plus a chunk-list reference model.
module tb_miner_nonce_scheduler;

    logic         clk;
    logic         reset_n;
    logic         cfg_start;
    logic         cfg_abort;
    logic [31:0]  cfg_first;
    logic [31:0]  cfg_last;
    logic [3:0]   core_start;
    logic [127:0] core_base;
    logic [35:0]  core_count;
    logic [3:0]   core_abort;
    logic [3:0]   core_busy;
    logic [3:0]   core_found;
    logic [127:0] core_found_nonce;
    logic         busy;
    logic         complete;
    logic         found;
    logic [31:0]  found_nonce;

    int checks;
    int errors;
    int cyc;
    int t0;
    int dur_lo;
    int dur_hi;
    int rem[4];
    bit pend[4];
    bit multi_seen;

    int          obs_core[$];
    int          obs_cyc[$];
    logic [31:0] obs_base[$];
    logic [8:0]  obs_cnt[$];
    logic [31:0] exp_base[$];
    logic [8:0]  exp_cnt[$];

    miner_nonce_scheduler dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .i_cfg_start        (cfg_start),
        .i_cfg_abort        (cfg_abort),
        .i_cfg_nonce_first  (cfg_first),
        .i_cfg_nonce_last   (cfg_last),
        .o_core_start       (core_start),
        .o_core_base        (core_base),
        .o_core_count       (core_count),
        .o_core_abort       (core_abort),
        .i_core_busy        (core_busy),
        .i_core_found       (core_found),
        .i_core_found_nonce (core_found_nonce),
        .o_busy             (busy),
        .o_complete         (complete),
        .o_found            (found),
        .o_found_nonce      (found_nonce)
    );

    always #5 clk = ~clk;

    // One cycle: clear pulses, advance the core model, log dispatches.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        cfg_start  = 1'b0;
        cfg_abort  = 1'b0;
        core_found = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            if (pend[i]) begin
                core_busy[i] = 1'b1;
                rem[i] = $urandom_range(dur_hi, dur_lo);
            end else if (core_busy[i]) begin
                if (core_abort[i] || rem[i] <= 1) core_busy[i] = 1'b0;
                else rem[i]--;
            end
            pend[i] = core_start[i];
            if (core_start[i]) begin
                obs_core.push_back(i);
                obs_cyc.push_back(cyc);
                obs_base.push_back(core_base[i*32 +: 32]);
                obs_cnt.push_back(core_count[i*9 +: 9]);
            end
        end
        if ($countones(core_start) > 1) multi_seen = 1'b1;
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        cfg_start  = 1'b0;
        cfg_abort  = 1'b0;
        core_found = 4'b0000;
        core_busy  = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            pend[i] = 1'b0;
            rem[i]  = 0;
        end
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
    endtask

    // Reference chunk list: consecutive 256-nonce slices of [f, l], last one trimmed.
    task automatic start_search(input longint f, input longint l);
        longint c;
        exp_base.delete();
        exp_cnt.delete();
        obs_core.delete();
        obs_cyc.delete();
        obs_base.delete();
        obs_cnt.delete();
        multi_seen = 1'b0;
        for (longint n = f; n <= l; n += 256) begin
            c = (l - n + 1 < 256) ? (l - n + 1) : 256;
            exp_base.push_back(32'(n));
            exp_cnt.push_back(9'(c));
        end
        cfg_first = 32'(f);
        cfg_last  = 32'(l);
        cfg_start = 1'b1;
        t0 = cyc;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < budget; n++) begin
            tick();
            if (complete) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_dispatches(input int num, input int budget);
        for (int n = 0; n < budget && obs_core.size() < num; n++) tick();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({core_start, core_abort, busy, complete, found} !== 11'd0) begin
            errors++;
            $display("FAIL reset_ctrl: got start=%h abort=%h busy=%b complete=%b found=%b, want all 0",
                     core_start, core_abort, busy, complete, found);
        end
        checks++;
        if (core_base !== 128'd0 || core_count !== 36'd0 || found_nonce !== 32'd0) begin
            errors++;
            $display("FAIL reset_data: got base=%h count=%h nonce=%h, want 0", core_base, core_count, found_nonce);
        end
    endtask

    task automatic test_full_range();
        bit ok;
        do_reset();
        dur_lo = 20; dur_hi = 25;
        start_search(64'd0, 64'd1023);
        tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL full_busy: got %b want 1", busy);
        end
        wait_done(500, ok);
        checks++;
        if (!ok || found !== 1'b0 || core_busy !== 4'd0) begin
            errors++;
            $display("FAIL full_done: got complete=%b found=%b core_busy=%h, want 1/0/0", ok, found, core_busy);
        end
        checks++;
        if (obs_core.size() != 4) begin
            errors++;
            $display("FAIL full_ndisp: got %0d dispatches want 4", obs_core.size());
        end
        for (int j = 0; j < 4 && j < obs_core.size(); j++) begin
            checks++;
            if (obs_core[j] != j || obs_cyc[j] != t0 + 1 + j || obs_base[j] !== 32'(j * 256) || obs_cnt[j] !== 9'h100) begin
                errors++;
                $display("FAIL full_chunk%0d: got core=%0d cyc=+%0d base=%h cnt=%h want core=%0d cyc=+%0d base=%h cnt=100",
                         j, obs_core[j], obs_cyc[j] - t0, obs_base[j], obs_cnt[j], j, j + 1, j * 256);
            end
        end
    endtask

    task automatic test_partial();
        bit ok;
        do_reset();
        dur_lo = 5; dur_hi = 8;
        start_search(64'h100, 64'h1A0);
        wait_done(200, ok);
        checks++;
        if (!ok || obs_core.size() != 1) begin
            errors++;
            $display("FAIL partial_done: got complete=%b dispatches=%0d want 1/1", ok, obs_core.size());
        end else begin
            checks++;
            if (obs_core[0] != 0 || obs_base[0] !== 32'h100 || obs_cnt[0] !== 9'h0A1) begin
                errors++;
                $display("FAIL partial_chunk: got core=%0d base=%h cnt=%h want 0/100/0a1", obs_core[0], obs_base[0], obs_cnt[0]);
            end
        end
    endtask

    task automatic test_top_of_range();
        bit ok;
        do_reset();
        dur_lo = 3; dur_hi = 6;
        start_search(64'hFFFFFF00, 64'hFFFFFFFF);
        wait_done(200, ok);
        repeat (20) tick();
        checks++;
        if (!ok || obs_core.size() != 1) begin
            errors++;
            $display("FAIL top_nowrap: got complete=%b dispatches=%0d want 1/1", ok, obs_core.size());
        end else begin
            checks++;
            if (obs_base[0] !== 32'hFFFFFF00 || obs_cnt[0] !== 9'h100) begin
                errors++;
                $display("FAIL top_chunk: got base=%h cnt=%h want ffffff00/100", obs_base[0], obs_cnt[0]);
            end
        end
    endtask

    task automatic test_empty();
        do_reset();
        start_search(64'h500, 64'h4FF);
        tick();
        checks++;
        if (complete !== 1'b0) begin
            errors++;
            $display("FAIL empty_t1: got complete=%b want 0", complete);
        end
        tick();
        checks++;
        if (complete !== 1'b1 || found !== 1'b0 || obs_core.size() != 0) begin
            errors++;
            $display("FAIL empty_t2: got complete=%b found=%b dispatches=%0d want 1/0/0", complete, found, obs_core.size());
        end
    endtask

    task automatic test_found_simul();
        bit ok;
        bit abort_bad;
        do_reset();
        dur_lo = 40; dur_hi = 50;
        start_search(64'd0, 64'hFFFF);
        wait_dispatches(4, 20);
        tick();
        tick();
        core_found_nonce = 128'd0;
        core_found_nonce[63:32] = 32'h42;
        core_found_nonce[95:64] = 32'h12345678;
        core_found = 4'b0110;
        tick();
        checks++;
        if (found !== 1'b1 || found_nonce !== 32'h42 || core_abort !== 4'hF) begin
            errors++;
            $display("FAIL found_latch: got found=%b nonce=%h abort=%h want 1/00000042/f", found, found_nonce, core_abort);
        end
        core_found_nonce[127:96] = 32'hDEAD;
        core_found = 4'b1000;
        abort_bad = 1'b0;
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            tick();
            if (complete) begin
                ok = 1'b1;
                break;
            end
            if (core_abort !== 4'hF) abort_bad = 1'b1;
        end
        checks++;
        if (!ok || abort_bad || core_abort !== 4'h0) begin
            errors++;
            $display("FAIL found_drain: got complete=%b abort_dropped=%b abort_at_done=%h want 1/0/0", ok, abort_bad, core_abort);
        end
        checks++;
        if (found_nonce !== 32'h42 || obs_core.size() != 4) begin
            errors++;
            $display("FAIL found_final: got nonce=%h dispatches=%0d want 00000042/4", found_nonce, obs_core.size());
        end
    endtask

    task automatic test_abort();
        bit ok;
        do_reset();
        dur_lo = 2; dur_hi = 3;
        start_search(64'd0, 64'd3071);
        wait_dispatches(4, 20);
        cfg_abort = 1'b1;
        tick();
        checks++;
        if (core_abort !== 4'hF || busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_level: got abort=%h busy=%b want f/1", core_abort, busy);
        end
        core_found_nonce[31:0] = 32'h77;
        core_found = 4'b0001;
        wait_done(200, ok);
        checks++;
        if (!ok || found !== 1'b0 || obs_core.size() != 4 || core_abort !== 4'h0) begin
            errors++;
            $display("FAIL abort_done: got complete=%b found=%b dispatches=%0d abort=%h want 1/0/4/0",
                     ok, found, obs_core.size(), core_abort);
        end
    endtask

    task automatic test_start_ignored_and_reset();
        do_reset();
        dur_lo = 50; dur_hi = 60;
        start_search(64'd0, 64'hFFFF);
        wait_dispatches(2, 20);
        cfg_first = 32'h5000_0000;
        cfg_start = 1'b1;
        wait_dispatches(3, 20);
        checks++;
        if (obs_core.size() != 3 || obs_base[2] !== 32'h200) begin
            errors++;
            $display("FAIL start_ignored: got dispatches=%0d base=%h want 3/00000200", obs_core.size(), obs_base[2]);
        end
        reset_n = 1'b0;
        tick();
        checks++;
        if ({core_start, core_abort, busy, complete, found} !== 11'd0 || core_base !== 128'd0
            || core_count !== 36'd0 || found_nonce !== 32'd0) begin
            errors++;
            $display("FAIL midrun_reset: got start=%h busy=%b base=%h count=%h want all 0", core_start, busy, core_base, core_count);
        end
        do_reset();
    endtask

    task automatic test_random();
        bit          ok;
        bit          inj;
        bit          injected;
        int          inj_at;
        int          bad;
        logic [3:0]  mask;
        logic [31:0] exp_nonce;
        longint      f;
        longint      l;
        for (int it = 0; it < 8; it++) begin
            dur_lo = $urandom_range(4, 1);
            dur_hi = dur_lo + $urandom_range(8, 0);
            f = (it % 3 == 0) ? 64'hFFFFFFFF - longint'($urandom_range(3000, 0)) : longint'($urandom);
            l = f + longint'($urandom_range(20000, 1)) - 1;
            if (l > 64'hFFFFFFFF) l = 64'hFFFFFFFF;
            if (it == 4 && f > 0) l = f - 1;
            inj       = $urandom_range(1, 0);
            inj_at    = $urandom_range(30, 1);
            injected  = 1'b0;
            exp_nonce = 32'd0;
            start_search(f, l);
            ok = 1'b0;
            for (int n = 0; n < 5000; n++) begin
                tick();
                if (complete) begin
                    ok = 1'b1;
                    break;
                end
                if (inj && !injected && (cyc - t0) >= inj_at && (|core_busy)) begin
                    mask = core_busy & 4'($urandom_range(15, 1));
                    if (mask == 4'd0) mask = core_busy;
                    for (int i = 0; i < 4; i++) core_found_nonce[i*32 +: 32] = $urandom;
                    for (int i = 3; i >= 0; i--) if (mask[i]) exp_nonce = core_found_nonce[i*32 +: 32];
                    core_found = mask;
                    injected   = 1'b1;
                end
            end
            checks++;
            if (!ok || found !== injected || (injected && found_nonce !== exp_nonce)) begin
                errors++;
                $display("FAIL rand%0d_result: got complete=%b found=%b nonce=%h want 1/%b/%h",
                         it, ok, found, found_nonce, injected, exp_nonce);
            end
            bad = 0;
            for (int j = 0; j < obs_base.size(); j++) begin
                if (j >= exp_base.size() || obs_base[j] !== exp_base[j] || obs_cnt[j] !== exp_cnt[j]) bad++;
            end
            checks++;
            if (bad != 0 || multi_seen || (!injected && obs_base.size() != exp_base.size())) begin
                errors++;
                $display("FAIL rand%0d_chunks: got %0d dispatches (%0d wrong, multi=%b) want %0d chunks",
                         it, obs_base.size(), bad, multi_seen, exp_base.size());
            end
        end
    endtask

    initial begin
        clk              = 1'b0;
        checks           = 0;
        errors           = 0;
        cyc              = 0;
        dur_lo           = 1;
        dur_hi           = 1;
        cfg_first        = 32'd0;
        cfg_last         = 32'd0;
        core_found_nonce = 128'd0;
        multi_seen       = 1'b0;
        test_reset();
        test_full_range();
        test_partial();
        test_top_of_range();
        test_empty();
        test_found_simul();
        test_abort();
        test_start_ignored_and_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
